// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: user request/response and RTC bus-buffer/strobe signals of one sequencer.
//  slave modport  : the sequencer (takes req_wr/req_rd/addr/wdata/buf_din, drives the rest)
//  master modport : the requester plus bus buffer side (drives requests and buf_din)
//  req_wr/req_rd/addr/wdata : access request; busy/done/rdata : access status and read result
//  buf_dir/buf_dout/buf_din : bidirectional buffer control and data
//  rtc_cs_n/rtc_rd_n/rtc_wr_n/rtc_ad : RTC strobes
interface rtc_bus_sequencer_if;
  logic       req_wr;
  logic       req_rd;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       buf_dir;
  logic [7:0] buf_dout;
  logic [7:0] buf_din;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_ad;
  modport slave (
    input  req_wr, req_rd, addr, wdata, buf_din,
    output busy, done, rdata, buf_dir, buf_dout, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad
  );
  modport master (
    output req_wr, req_rd, addr, wdata, buf_din,
    input  busy, done, rdata, buf_dir, buf_dout, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs one RTC register write or read over the multiplexed 8-bit address/data bus.
//  clk   : system clock, posedge
//  reset : synchronous, active-low
//  bus   : rtc_bus_sequencer_if.slave (requests, status, buffer control, RTC strobes)
//  T_PH  : cycles per bus phase (2..15)
module rtc_bus_sequencer #(
  parameter int T_PH = 4
) (
  input logic              clk,
  input logic              reset,
  rtc_bus_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] A_SET = 3'd1;
  localparam logic [2:0] A_STB = 3'd2;
  localparam logic [2:0] A_HLD = 3'd3;
  localparam logic [2:0] D_SET = 3'd4;
  localparam logic [2:0] D_STB = 3'd5;
  localparam logic [2:0] D_HLD = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;
  logic [2:0] st, st_n;
  logic [3:0] cnt, cnt_n;
  logic       op_rd, op_n;
  logic [7:0] addr_q, wdata_q, addr_n, wdata_n;
  logic       last, a_ph, d_ph;
  assign last = cnt == 4'(T_PH - 1);
  // Phase states are numbered consecutively, so the timed walk is just +1.
  always_comb begin
    st_n  = st;
    cnt_n = 4'd0;
    if (st == IDLE)
      st_n = (bus.req_wr | bus.req_rd) ? A_SET : IDLE;
    else if (st == DONE)
      st_n = IDLE;
    else begin
      st_n  = last ? st + 3'd1 : st;
      cnt_n = last ? 4'd0 : cnt + 4'd1;
    end
  end
  // Outputs are registered from the next state; in IDLE the incoming request
  // is what the first A_SET cycle must already reflect.
  assign op_n    = (st == IDLE) ? !bus.req_wr : op_rd;
  assign addr_n  = (st == IDLE) ? bus.addr : addr_q;
  assign wdata_n = (st == IDLE) ? bus.wdata : wdata_q;
  assign a_ph    = st_n inside {[A_SET:A_HLD]};
  assign d_ph    = st_n inside {[D_SET:D_HLD]};
  always_ff @(posedge clk) begin
    if (!reset) begin
      st           <= IDLE;
      cnt          <= 4'd0;
      op_rd        <= 1'b0;
      addr_q       <= 8'd0;
      wdata_q      <= 8'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rdata    <= 8'd0;
      bus.buf_dir  <= 1'b0;
      bus.buf_dout <= 8'd0;
      bus.rtc_cs_n <= 1'b1;
      bus.rtc_rd_n <= 1'b1;
      bus.rtc_wr_n <= 1'b1;
      bus.rtc_ad   <= 1'b0;
    end else begin
      st           <= st_n;
      cnt          <= cnt_n;
      op_rd        <= op_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      bus.busy     <= st_n != IDLE;
      bus.done     <= st_n == DONE;
      bus.rtc_cs_n <= !(a_ph | d_ph);
      bus.rtc_ad   <= d_ph;
      // A read releases the bus from the first D_SET cycle for turnaround.
      bus.buf_dir  <= a_ph | (d_ph & !op_n);
      bus.buf_dout <= a_ph ? addr_n : (d_ph & !op_n) ? wdata_n : 8'd0;
      bus.rtc_wr_n <= !((st_n == A_STB) | ((st_n == D_STB) & !op_n));
      bus.rtc_rd_n <= !((st_n == D_STB) & op_n);
      // buf_din lags the bus by one clock: during the first D_HLD cycle it
      // holds the bus value seen at the edge that ended D_STB.
      if (st == D_HLD && cnt == 4'd0 && op_rd)
        bus.rdata <= bus.buf_din;
    end
  end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed table plus corner sequences for T_PH=4 and T_PH=2 instances.
module tb_rtc_bus_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sel = 1'b0;
  logic [7:0] rv = 8'h00;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rtc_bus_sequencer_if b4();
  rtc_bus_sequencer_if b2();
  rtc_bus_sequencer #(.T_PH(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  rtc_bus_sequencer #(.T_PH(2)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  logic [7:0] bus4, bus2;
  assign bus4 = b4.buf_dir ? b4.buf_dout : (!b4.rtc_rd_n ? rv : 8'h00);
  assign bus2 = b2.buf_dir ? b2.buf_dout : (!b2.rtc_rd_n ? rv : 8'h00);
  initial begin
    b4.buf_din = 8'h00;
    b2.buf_din = 8'h00;
  end
  always @(posedge clk) begin
    b4.buf_din <= bus4;
    b2.buf_din <= bus2;
  end
  logic s_busy, s_done, s_dir, s_cs_n, s_rd_n, s_wr_n, s_ad;
  logic [7:0] s_dout, s_rdata;
  assign s_busy  = sel ? b2.busy : b4.busy;
  assign s_done  = sel ? b2.done : b4.done;
  assign s_dir   = sel ? b2.buf_dir : b4.buf_dir;
  assign s_cs_n  = sel ? b2.rtc_cs_n : b4.rtc_cs_n;
  assign s_rd_n  = sel ? b2.rtc_rd_n : b4.rtc_rd_n;
  assign s_wr_n  = sel ? b2.rtc_wr_n : b4.rtc_wr_n;
  assign s_ad    = sel ? b2.rtc_ad : b4.rtc_ad;
  assign s_dout  = sel ? b2.buf_dout : b4.buf_dout;
  assign s_rdata = sel ? b2.rdata : b4.rdata;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask
  task automatic inv(input string n, input logic cs_n, rd_n, wr_n, dir, busy);
    checks++;
    if ((!rd_n && !wr_n) || (cs_n && (!rd_n || !wr_n)) || (dir && !rd_n) || (!busy && dir)) begin
      errors++;
      $display("FAIL inv_%s cs_n=%b rd_n=%b wr_n=%b dir=%b busy=%b", n, cs_n, rd_n, wr_n, dir, busy);
    end
  endtask
  always @(negedge clk) begin
    inv("t4", b4.rtc_cs_n, b4.rtc_rd_n, b4.rtc_wr_n, b4.buf_dir, b4.busy);
    inv("t2", b2.rtc_cs_n, b2.rtc_rd_n, b2.rtc_wr_n, b2.buf_dir, b2.busy);
  end
  task automatic set_req(input logic w, input logic r);
    if (sel) begin
      b2.req_wr = w; b2.req_rd = r;
    end else begin
      b4.req_wr = w; b4.req_rd = r;
    end
  endtask
  typedef struct {
    logic s, w, r;
    logic [7:0] a, d, v;
    int wa_first, wa_n, wd_first, wd_n, rd_first, rd_n, dd, done_cyc, busy_n;
    logic [7:0] rdata;
  } vec_t;
  int r_wa_first, r_wa_n, r_wd_first, r_wd_n, r_rd_first, r_rd_n, r_dd, r_done_cyc, r_done_n, r_busy_n, r_busy_after;
  logic [7:0] r_rdata;
  task automatic run(input logic s, input logic w, input logic r, input logic [7:0] a, input logic [7:0] d, input logic [7:0] v);
    int k;
    sel = s;
    @(negedge clk);
    b4.addr = a; b2.addr = a; b4.wdata = d; b2.wdata = d; rv = v;
    set_req(w, r);
    @(posedge clk);
    #1 set_req(1'b0, 1'b0);
    {r_wa_first, r_wa_n, r_wd_first, r_wd_n, r_rd_first, r_rd_n} = '0;
    {r_dd, r_done_cyc, r_done_n, r_busy_n, r_busy_after} = '0;
    r_rdata = 8'h00;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (r_done_cyc != 0 && k == r_done_cyc + 1) begin
        r_busy_after = int'(s_busy);
        break;
      end
      if (!s_wr_n && !s_ad && s_dir && s_dout == a) begin
        if (r_wa_n == 0) r_wa_first = k;
        r_wa_n++;
      end
      if (!s_wr_n && s_ad && s_dir && s_dout == d) begin
        if (r_wd_n == 0) r_wd_first = k;
        r_wd_n++;
      end
      if (!s_rd_n) begin
        if (r_rd_n == 0) r_rd_first = k;
        r_rd_n++;
      end
      if (s_ad && s_dir && !s_cs_n) r_dd++;
      if (s_busy) r_busy_n++;
      if (s_done) begin
        r_done_n++;
        if (r_done_cyc == 0) begin
          r_done_cyc = k;
          r_rdata = s_rdata;
        end
      end
    end
  endtask
  vec_t vt[6];
  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 8'h21, 8'h59, 8'h00,  5, 4, 17, 4,  0, 0, 12, 25, 25, 8'h00};
    vt[1] = '{1'b0, 1'b0, 1'b1, 8'h22, 8'h00, 8'hA7,  5, 4,  0, 0, 17, 4,  0, 25, 25, 8'hA7};
    vt[2] = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h3C, 8'h55,  5, 4, 17, 4,  0, 0, 12, 25, 25, 8'hA7};
    vt[3] = '{1'b1, 1'b1, 1'b0, 8'h21, 8'h59, 8'h00,  3, 2,  9, 2,  0, 0,  6, 13, 13, 8'h00};
    vt[4] = '{1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 8'hA7,  3, 2,  0, 0,  9, 2,  0, 13, 13, 8'hA7};
    vt[5] = '{1'b0, 1'b0, 1'b1, 8'h0F, 8'h00, 8'h3C,  5, 4,  0, 0, 17, 4,  0, 25, 25, 8'h3C};
    {b4.req_wr, b4.req_rd, b2.req_wr, b2.req_rd} = '0;
    b4.addr = 8'h00; b2.addr = 8'h00; b4.wdata = 8'h00; b2.wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(b4.busy), 0);
    chk("rst_cs_n", int'(b4.rtc_cs_n), 1);
    chk("rst_strobes", int'({b4.rtc_rd_n, b4.rtc_wr_n, b4.rtc_ad, b4.buf_dir}), 4'b1100);
    chk("rst_dout_rdata", int'({b4.buf_dout, b4.rdata, b4.done}), 0);
    chk("rst2_cs_busy", int'({b2.rtc_cs_n, b2.busy, b2.buf_dir}), 3'b100);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run(vt[i].s, vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].v);
      chk($sformatf("v%0d_wa_first", i), r_wa_first, vt[i].wa_first);
      chk($sformatf("v%0d_wa_n", i), r_wa_n, vt[i].wa_n);
      chk($sformatf("v%0d_wd_first", i), r_wd_first, vt[i].wd_first);
      chk($sformatf("v%0d_wd_n", i), r_wd_n, vt[i].wd_n);
      chk($sformatf("v%0d_rd_first", i), r_rd_first, vt[i].rd_first);
      chk($sformatf("v%0d_rd_n", i), r_rd_n, vt[i].rd_n);
      chk($sformatf("v%0d_dir_data", i), r_dd, vt[i].dd);
      chk($sformatf("v%0d_done_cyc", i), r_done_cyc, vt[i].done_cyc);
      chk($sformatf("v%0d_done_n", i), r_done_n, 1);
      chk($sformatf("v%0d_busy_n", i), r_busy_n, vt[i].busy_n);
      chk($sformatf("v%0d_busy_after", i), r_busy_after, 0);
      chk($sformatf("v%0d_rdata", i), int'(r_rdata), int'(vt[i].rdata));
    end
    // Reset held for 3 clocks in the middle of a read strobe.
    sel = 1'b0;
    @(negedge clk);
    b4.addr = 8'h2A; rv = 8'h9A; b4.req_rd = 1'b1;
    @(posedge clk);
    #1 b4.req_rd = 1'b0;
    repeat (18) @(negedge clk);
    chk("mid_rd_low", int'(b4.rtc_rd_n), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_strobes", int'({b4.rtc_cs_n, b4.rtc_rd_n, b4.rtc_wr_n}), 3'b111);
    chk("abort_dir_busy", int'({b4.buf_dir, b4.busy, b4.done}), 0);
    chk("abort_rdata", int'(b4.rdata), 0);
    begin
      int dn;
      dn = 0;
      repeat (2) begin
        @(negedge clk);
        dn += int'(b4.done);
      end
      reset = 1'b1;
      repeat (40) begin
        @(negedge clk);
        dn += int'(b4.done) + int'(!b4.rtc_cs_n);
      end
      chk("abort_no_done", dn, 0);
    end
    // Requests during an access are dropped.
    begin
      int dn;
      logic [7:0] rd;
      dn = 0; rd = 8'h00;
      @(negedge clk);
      b4.addr = 8'h10; rv = 8'h11; b4.req_rd = 1'b1;
      @(posedge clk);
      #1 b4.req_rd = 1'b0;
      for (int k = 1; k <= 70; k++) begin
        @(negedge clk);
        if (s_done) begin dn++; rd = s_rdata; end
        b4.req_rd = (k == 5 || k == 10 || k == 25);
        b4.req_wr = (k == 10);
      end
      b4.req_rd = 1'b0; b4.req_wr = 1'b0;
      chk("ignore_done_n", dn, 1);
      chk("ignore_rdata", int'(rd), 8'h11);
    end
    // Read then write back-to-back.
    begin
      int dc, k, dc2;
      dc = 0; dc2 = 0; k = 0;
      @(negedge clk);
      b4.addr = 8'h40; rv = 8'h66; b4.req_rd = 1'b1;
      @(posedge clk);
      #1 b4.req_rd = 1'b0;
      while (k < 120 && dc2 == 0) begin
        @(negedge clk);
        k++;
        if (dc != 0 && k == dc + 1) chk("b2b_idle", int'(b4.busy), 0);
        if (dc != 0 && k == dc + 2) begin
          chk("b2b_accept", int'({b4.busy, b4.rtc_cs_n}), 2'b10);
          chk("b2b_rd_rdata", int'(b4.rdata), 8'h66);
          b4.req_wr = 1'b0;
        end
        if (b4.done && dc != 0 && k > dc) dc2 = k;
        if (b4.done && dc == 0) begin
          dc = k;
          b4.addr = 8'h41; b4.wdata = 8'h77; b4.req_wr = 1'b1;
        end
      end
      b4.req_wr = 1'b0;
      chk("b2b_rd_done", dc, 25);
      chk("b2b_wr_done", dc2, 51);
      chk("b2b_wr_rdata", int'(b4.rdata), 8'h66);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
